// File: rtl/eth_fcs_tx.sv
// Transmit-side Ethernet FCS generator for a 2-bit dibit stream.
// Forwards the frame body with one cycle of latency, zero-pads short frames,
// appends the reflected CRC-32 (LSB first) and holds off new frames for the
// inter-frame gap.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for a rising axiiv; ready high
//   S_DATA | forwarding body dibits; ready high
//   S_PAD  | emitting zero dibits until the minimum length is reached
//   S_FCS  | emitting the 16 FCS dibits, done with the last one
//   S_GAP  | output idle for the inter-frame gap, input dropped
module eth_fcs_tx #(
  parameter int MIN_DIBITS = 240,
  parameter int IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] axiid,
  input  logic       axiiv,
  output logic       axiir,
  output logic [1:0] axiod,
  output logic       axiov,
  output logic       done
);

  localparam int LEN_W = (MIN_DIBITS > 0) ? $clog2(MIN_DIBITS + 1) : 1;
  localparam int GAP_W = (IFG_DIBITS > 0) ? $clog2(IFG_DIBITS + 1) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MIN_DIBITS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_DIBITS);
  localparam logic [31:0]      CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_FCS, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       idx_q, idx_d;
  logic             discard_q, discard_d;
  logic             axiiv_prev_q;
  logic [1:0]       axiod_q, axiod_d;
  logic             axiov_q, axiov_d;
  logic             done_q, done_d;

  logic [31:0]      fcs;
  logic             start;
  logic [LEN_W-1:0] len_inc;

  // Two bits of the reflected CRC, bit[0] of the dibit first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs     = ~crc_q;
  assign len_inc = len_q + LEN_W'(1);
  // A frame starts only on a true rising edge; a frame already in flight
  // when IDLE is entered is marked for discard instead.
  assign start   = axiiv && !axiiv_prev_q && !discard_q;

  // State, datapath and registered outputs; the edge detector keeps sampling
  // through reset so a frame straddling reset is never taken as a new start.
  always_ff @(posedge clk) begin
    axiiv_prev_q <= axiiv;
    if (rst) begin
      state_q   <= S_IDLE;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      discard_q <= 1'b0;
      axiod_q   <= '0;
      axiov_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      discard_q <= discard_d;
      axiod_q   <= axiod_d;
      axiov_q   <= axiov_d;
      done_q    <= done_d;
    end
  end

  // Next state, CRC accumulation and the length / FCS / gap counters.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    discard_d = discard_q;
    if (!axiiv) discard_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DATA;
          crc_d   = crc_dibit(crc_q, axiid);
          len_d   = (LEN_MAX != '0) ? LEN_W'(1) : '0;
        end else if (axiiv) begin
          discard_d = 1'b1;
        end
      end
      S_DATA: begin
        if (axiiv) begin
          crc_d = crc_dibit(crc_q, axiid);
          len_d = (len_q < LEN_MAX) ? len_inc : len_q;
        end else if (len_q < LEN_MAX) begin
          // First pad dibit goes out in the cycle the body ends.
          crc_d   = crc_dibit(crc_q, 2'b00);
          len_d   = len_inc;
          idx_d   = '0;
          state_d = (len_inc == LEN_MAX) ? S_FCS : S_PAD;
        end else begin
          // FCS dibit 0 goes out here, so the FCS state resumes at 1.
          idx_d   = 4'd1;
          state_d = S_FCS;
        end
      end
      S_PAD: begin
        crc_d = crc_dibit(crc_q, 2'b00);
        len_d = len_inc;
        if (len_inc == LEN_MAX) begin
          idx_d   = '0;
          state_d = S_FCS;
        end
      end
      S_FCS: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_IDLE;
          crc_d   = CRC_INIT;
          len_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output dibit, valid and done for the next cycle.
  always_comb begin
    axiod_d = '0;
    axiov_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          axiod_d = axiid;
          axiov_d = 1'b1;
        end
      end
      S_DATA: begin
        axiov_d = 1'b1;
        if (axiiv)                axiod_d = axiid;
        else if (len_q < LEN_MAX) axiod_d = 2'b00;
        else                      axiod_d = fcs[1:0];
      end
      S_PAD: axiov_d = 1'b1;
      S_FCS: begin
        axiov_d = 1'b1;
        axiod_d = fcs[{idx_q, 1'b0} +: 2];
        done_d  = (idx_q == 4'd15);
      end
      default: ;
    endcase
  end

  assign axiir = (state_q == S_IDLE) || (state_q == S_DATA);
  assign axiod = axiod_q;
  assign axiov = axiov_q;
  assign done  = done_q;

endmodule
